sr_latch_writer: RTL and testbench
==================================

# sr_latch_writer

Write controller for a bank of WIDTH gated NAND SR latches of the `flipflop` type. Accepts a target word over a valid/ready handshake. From the latch readback it computes per-bit set/reset excitation and pulses the shared latch gate, then reads the bank back to confirm the write. A bounded number of retries is allowed before it reports an error. It is the writer side of the latch bank: it owns `s`, `r` and the gate, and the bank's `q` outputs come back as readback.

## Interface
- WIDTH, 8, number of latches in the bank (1..32)
- PULSE_CYCLES, 2, gate-high duration in clock cycles (>=1)
- SETTLE_CYCLES, 1, gate-low wait before readback (>=0; 0 skips SETTLE)
- MAX_RETRY, 2, extra write attempts after the first (0..15)

- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; all state and outputs cleared immediately
- req_valid  input  1  target word offered
- req_ready  output  1  high only in IDLE
- req_data  input  WIDTH  target word
- q_in  input  WIDTH  latch bank `q` readback
- s_out  output  WIDTH  per-latch set drive
- r_out  output  WIDTH  per-latch reset drive
- gate  output  1  shared latch clock/enable
- done  output  1  one-cycle pulse at end of every accepted request
- error  output  1  valid with done; held until next acceptance
- retry_count  output  4  attempts beyond the first used by the last or current request

## Operation
- States: IDLE, SETUP, DRIVE, HOLD, SETTLE, CHECK.
- Accept = req_valid & req_ready on a rising edge. On acceptance:
  - latch target <= req_data;
  - clear error and retry_count.
- Excitation is computed from q_in sampled at that edge, per bit:
  - s_out = target & ~q_in;
  - r_out = ~target & q_in;
  - bits already correct get s=r=0 (hold).
- No-op request: if target == q_in at acceptance, s_out/r_out stay 0, gate never rises, FSM stays in IDLE and done pulses next cycle with error=0.
- IDLE -> SETUP (1 cycle, gate=0, s/r stable) -> DRIVE (PULSE_CYCLES cycles, gate=1) -> HOLD (1 cycle, gate=0, s/r still held) -> SETTLE (SETTLE_CYCLES cycles, s/r=0) -> CHECK (1 cycle).
- CHECK outcomes:
  - q_in == target: go to IDLE, done=1 next cycle, error=0.
  - Mismatch and retry_count < MAX_RETRY: retry_count+1, recompute s/r from current q_in, go to SETUP.
  - Mismatch and retry_count == MAX_RETRY: go to IDLE, done=1, error=1.
- Invariants:
  - s_out & r_out == 0 always, so the forbidden latch input is never driven.
  - gate is high only in DRIVE.
  - s_out/r_out never change while gate is high, nor in the cycles immediately before or after it.
- req_data is ignored outside the accept edge. req_ready is high in the cycle done pulses, so back-to-back requests are allowed.

## Timing
- Reset values:
  - state IDLE;
  - req_ready=1;
  - s_out=0, r_out=0, gate=0;
  - done=0, error=0, retry_count=0.
- Reset asserted mid-write drops gate and s/r asynchronously. Latch contents are then undefined, and no done is produced for the aborted request.
- Successful first attempt: acceptance at edge k puts SETUP in k..k+1, and done is high in the cycle after edge k+3+PULSE_CYCLES+SETTLE_CYCLES (k+6 with defaults).
- Each retry adds 3+PULSE_CYCLES+SETTLE_CYCLES cycles.
- No-op request: done is high in the cycle after edge k+1, and req_ready drops for that one cycle.
- All outputs are registered. q_in is sampled only at acceptance and in CHECK, and must be stable there. q_in is not synchronized.
- s/r change only on entry to SETUP (set) and on exit from HOLD (clear).

## Test plan
- Basic write: reset, bank q=0x00, request 0xA5.
  - Required: s_out=0xA5, r_out=0x00.
  - gate high exactly 2 cycles starting the 2nd cycle after acceptance.
  - done at acceptance+6, error=0, retry_count=0.
- Mixed excitation: bank q=0xF0, request 0x3C.
  - Required: s_out=0x0C, r_out=0xC0, s_out&r_out==0 every cycle.
  - q ends at 0x3C.
- No-op: bank q=0x5A, request 0x5A.
  - Required: gate never rises, s/r stay 0.
  - done one cycle after acceptance, error=0.
- Stuck bit: model bit 3 stuck at 0, request 0x08, MAX_RETRY=2.
  - Required: three gate pulses, retry_count=2.
  - done with error=1, and error stays 1 until the next acceptance.
- Reset mid-write: assert reset during the second DRIVE cycle.
  - Required: gate, s_out, r_out fall the same cycle, no done, req_ready=1.
  - A following request completes normally.
- Back-to-back: present 0x11 then 0xEE with req_valid held high.
  - Required: the second is accepted in the done cycle of the first, and both complete with error=0.

Source files
------------

// File: rtl/sr_latch_writer.sv
// Write controller for a bank of gated SR latches: excites s/r from readback,
// pulses the shared gate, verifies by readback and retries a bounded number of times.
module sr_latch_writer #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned PULSE_CYCLES  = 2,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned MAX_RETRY     = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] r_out,
   output logic             gate,
   output logic             done,
   output logic             error,
   output logic [3:0]       retry_count
);
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {IDLE, SETUP, DRIVE, HOLD, SETTLE, CHECK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
   logic             gate_q, gate_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             ready_q, ready_d;
   logic             noop_q, noop_d;
   logic [3:0]       retry_q, retry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   assign accept = req_valid & ready_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         target_q <= '0;
         s_q      <= '0;
         r_q      <= '0;
         gate_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         ready_q  <= 1'b1;
         noop_q   <= 1'b0;
         retry_q  <= 4'd0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         s_q      <= s_d;
         r_q      <= r_d;
         gate_q   <= gate_d;
         done_q   <= done_d;
         error_q  <= error_d;
         ready_q  <= ready_d;
         noop_q   <= noop_d;
         retry_q  <= retry_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      s_d      = s_q;
      r_d      = r_q;
      gate_d   = 1'b0;
      done_d   = 1'b0;
      error_d  = error_q;
      noop_d   = 1'b0;
      retry_d  = retry_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            // a no-op request completes from IDLE one cycle after acceptance
            if (noop_q) done_d = 1'b1;
            if (accept) begin
               target_d = req_data;
               error_d  = 1'b0;
               retry_d  = 4'd0;
               if (req_data == q_in) begin
                  noop_d = 1'b1;
               end else begin
                  s_d     = req_data & ~q_in;
                  r_d     = ~req_data & q_in;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = DRIVE;
            gate_d  = 1'b1;
            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
            end else begin
               gate_d = 1'b1;
               cnt_d  = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            s_d = '0;
            r_d = '0;
            if (SETTLE_CYCLES == 0) begin
               state_d = CHECK;
            end else begin
               state_d = SETTLE;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = CHECK;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         CHECK: begin
            if (q_in == target_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (retry_q < 4'(MAX_RETRY)) begin
               retry_d = retry_q + 4'd1;
               s_d     = target_q & ~q_in;
               r_d     = ~target_q & q_in;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
               error_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // ready is withheld during the no-op completion cycle
      ready_d = (state_d == IDLE) && !noop_d;
   end

   assign req_ready   = ready_q;
   assign s_out       = s_q;
   assign r_out       = r_q;
   assign gate        = gate_q;
   assign done        = done_q;
   assign error       = error_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Directed bench for sr_latch_writer with a behavioural gated SR latch bank
// (optional stuck-at-0 bits) closing the readback loop.
module tb_sr_latch_writer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_data = 8'h00;
   logic [7:0] q_in;
   logic [7:0] s_out;
   logic [7:0] r_out;
   logic       gate;
   logic       done;
   logic       error;
   logic [3:0] retry_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] bank = 8'h00;
   logic [7:0] stuck_mask = 8'h00;
   logic [7:0] preset_val = 8'h00;
   logic       preset_en = 1'b0;

   sr_latch_writer dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .q_in(q_in), .s_out(s_out), .r_out(r_out), .gate(gate),
      .done(done), .error(error), .retry_count(retry_count)
   );

   always #5 clock = ~clock;

   // latch bank: transparent while gate is high, updated mid-cycle
   always @(negedge clock) begin
      if (preset_en)  bank <= preset_val;
      else if (gate)  bank <= (bank | s_out) & ~r_out;
   end
   assign q_in = bank & ~stuck_mask;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic set_bank(input logic [7:0] v);
      preset_val = v;
      preset_en  = 1'b1;
      @(negedge clock);
      #1 preset_en = 1'b0;
   endtask

   // drives one request; samples are indexed by edges after the accept edge
   task automatic do_write(input logic [7:0] data, output int lat, output int gate_cyc,
                           output int pulses, output int first_gate, output logic [7:0] s0,
                           output logic [7:0] r0, output logic bad_sr, output logic err,
                           output logic [3:0] rc, output logic err_acc, output logic rdy_acc);
      logic       g_prev;
      logic [7:0] s_prev, r_prev;
      req_data  = data;
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      s0 = s_out; r0 = r_out; err_acc = error; rdy_acc = req_ready;
      lat = -1; gate_cyc = 0; pulses = 0; first_gate = -1; err = 1'bx; rc = 4'hx;
      bad_sr = ((s_out & r_out) != 8'h00);
      g_prev = gate; s_prev = s_out; r_prev = r_out;
      for (int i = 1; i <= 200 && lat < 0; i++) begin
         @(posedge clock); #1;
         if ((s_out & r_out) != 8'h00) bad_sr = 1'b1;
         if ((gate || g_prev) && (s_out !== s_prev || r_out !== r_prev)) bad_sr = 1'b1;
         if (gate) begin
            gate_cyc++;
            if (!g_prev) pulses++;
            if (first_gate < 0) first_gate = i;
         end
         if (done) begin lat = i; err = error; rc = retry_count; end
         g_prev = gate; s_prev = s_out; r_prev = r_out;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_bank(8'h00);
      repeat (2) @(posedge clock);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
      checks++; if (s_out !== 8'h00) begin errors++; $display("FAIL rst_s got %h want 00", s_out); end
      checks++; if (r_out !== 8'h00) begin errors++; $display("FAIL rst_r got %h want 00", r_out); end
      checks++; if (gate !== 1'b0) begin errors++; $display("FAIL rst_gate got %b want 0", gate); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error); end
      checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL rst_retry got %0d want 0", retry_count); end
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_basic_write();
      int lat, gc, pc, fg; logic [7:0] s0, r0; logic bad, err, ea, ra; logic [3:0] rc;
      set_bank(8'h00);
      do_write(8'hA5, lat, gc, pc, fg, s0, r0, bad, err, rc, ea, ra);
      checks++; if (s0 !== 8'hA5) begin errors++; $display("FAIL basic_s got %h want a5", s0); end
      checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL basic_r got %h want 00", r0); end
      checks++; if (fg !== 1) begin errors++; $display("FAIL basic_gate_start got %0d want 1", fg); end
      checks++; if (gc !== 2) begin errors++; $display("FAIL basic_gate_cycles got %0d want 2", gc); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", lat); end
      checks++; if (err !== 1'b0 || rc !== 4'd0) begin errors++; $display("FAIL basic_status got err=%b rc=%0d want err=0 rc=0", err, rc); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL basic_sr_rules got %b want 0", bad); end
      checks++; if (q_in !== 8'hA5) begin errors++; $display("FAIL basic_q got %h want a5", q_in); end
   endtask

   task automatic test_mixed();
      int lat, gc, pc, fg; logic [7:0] s0, r0; logic bad, err, ea, ra; logic [3:0] rc;
      set_bank(8'hF0);
      do_write(8'h3C, lat, gc, pc, fg, s0, r0, bad, err, rc, ea, ra);
      checks++; if (s0 !== 8'h0C) begin errors++; $display("FAIL mixed_s got %h want 0c", s0); end
      checks++; if (r0 !== 8'hC0) begin errors++; $display("FAIL mixed_r got %h want c0", r0); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mixed_sr_rules got %b want 0", bad); end
      checks++; if (lat !== 6 || err !== 1'b0) begin errors++; $display("FAIL mixed_done got lat=%0d err=%b want lat=6 err=0", lat, err); end
      checks++; if (q_in !== 8'h3C) begin errors++; $display("FAIL mixed_q got %h want 3c", q_in); end
   endtask

   task automatic test_noop();
      int lat, gc, pc, fg; logic [7:0] s0, r0; logic bad, err, ea, ra; logic [3:0] rc;
      set_bank(8'h5A);
      do_write(8'h5A, lat, gc, pc, fg, s0, r0, bad, err, rc, ea, ra);
      checks++; if (gc !== 0) begin errors++; $display("FAIL noop_gate got %0d want 0", gc); end
      checks++; if (s0 !== 8'h00 || r0 !== 8'h00) begin errors++; $display("FAIL noop_sr got s=%h r=%h want 00 00", s0, r0); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL noop_latency got %0d want 1", lat); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL noop_error got %b want 0", err); end
      checks++; if (ra !== 1'b0) begin errors++; $display("FAIL noop_ready_drop got %b want 0", ra); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL noop_ready_done got %b want 1", req_ready); end
   endtask

   task automatic test_stuck_bit();
      int lat, gc, pc, fg; logic [7:0] s0, r0; logic bad, err, ea, ra; logic [3:0] rc;
      set_bank(8'h00);
      stuck_mask = 8'h08;
      do_write(8'h08, lat, gc, pc, fg, s0, r0, bad, err, rc, ea, ra);
      checks++; if (pc !== 3) begin errors++; $display("FAIL stuck_pulses got %0d want 3", pc); end
      checks++; if (lat !== 18) begin errors++; $display("FAIL stuck_latency got %0d want 18", lat); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL stuck_error got %b want 1", err); end
      checks++; if (rc !== 4'd2) begin errors++; $display("FAIL stuck_retry got %0d want 2", rc); end
      repeat (3) @(posedge clock);
      #1;
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL stuck_error_held got %b want 1", error); end
      stuck_mask = 8'h00;
      set_bank(8'h00);
      do_write(8'h08, lat, gc, pc, fg, s0, r0, bad, err, rc, ea, ra);
      checks++; if (ea !== 1'b0) begin errors++; $display("FAIL stuck_error_clear got %b want 0", ea); end
      checks++; if (lat !== 6 || err !== 1'b0 || rc !== 4'd0) begin errors++; $display("FAIL stuck_recover got lat=%0d err=%b rc=%0d want 6 0 0", lat, err, rc); end
   endtask

   task automatic test_reset_mid_write();
      int lat, gc, pc, fg; logic [7:0] s0, r0; logic bad, err, ea, ra; logic [3:0] rc;
      logic saw_done;
      set_bank(8'h00);
      req_data = 8'hFF; req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #3;
      checks++; if (gate !== 1'b1 || s_out !== 8'hFF) begin errors++; $display("FAIL midrst_pre got gate=%b s=%h want 1 ff", gate, s_out); end
      reset = 1'b1;
      #1;
      checks++; if (gate !== 1'b0) begin errors++; $display("FAIL midrst_gate got %b want 0", gate); end
      checks++; if (s_out !== 8'h00 || r_out !== 8'h00) begin errors++; $display("FAIL midrst_sr got s=%h r=%h want 00 00", s_out, r_out); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", req_ready); end
      @(posedge clock); #1;
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (10) begin
         @(posedge clock); #1;
         if (done) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
      set_bank(8'h00);
      do_write(8'h81, lat, gc, pc, fg, s0, r0, bad, err, rc, ea, ra);
      checks++; if (lat !== 6 || err !== 1'b0 || q_in !== 8'h81) begin errors++; $display("FAIL midrst_next got lat=%0d err=%b q=%h want 6 0 81", lat, err, q_in); end
   endtask

   task automatic test_back_to_back();
      int first, second;
      logic [7:0] s2, r2;
      logic e1, e2, rdy1;
      set_bank(8'h00);
      req_data = 8'h11; req_valid = 1'b1;
      @(posedge clock); #1;
      req_data = 8'hEE;
      first = -1; second = -1; s2 = 8'h00; r2 = 8'h00; e1 = 1'b1; e2 = 1'b1; rdy1 = 1'b0;
      for (int i = 1; i <= 60 && second < 0; i++) begin
         @(posedge clock); #1;
         if (first >= 0 && i == first + 1) begin
            s2 = s_out; r2 = r_out; req_valid = 1'b0;
         end
         if (done) begin
            if (first < 0) begin first = i; e1 = error; rdy1 = req_ready; end
            else begin second = i; e2 = error; end
         end
      end
      req_valid = 1'b0;
      checks++; if (first !== 6 || e1 !== 1'b0) begin errors++; $display("FAIL b2b_first got lat=%0d err=%b want 6 0", first, e1); end
      checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b want 1", rdy1); end
      checks++; if (s2 !== 8'hEE || r2 !== 8'h11) begin errors++; $display("FAIL b2b_second_sr got s=%h r=%h want ee 11", s2, r2); end
      checks++; if (second !== 13 || e2 !== 1'b0) begin errors++; $display("FAIL b2b_second got lat=%0d err=%b want 13 0", second, e2); end
      checks++; if (q_in !== 8'hEE) begin errors++; $display("FAIL b2b_q got %h want ee", q_in); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_mixed();
      test_noop();
      test_stuck_bit();
      test_reset_mid_write();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
